// File: rtl/motion_state_sequencer.sv
// Direction sequencer for the H-bridge: dead-time between opposing directions, overcurrent fault hold-off.
// Optional build macro MOTION_FAULT_COUNT_EN enables the saturating fault_count counter.
module motion_state_sequencer #(
    parameter int DEADTIME_CYC   = 50000,
    parameter int FAULT_HOLD_CYC = 10000000,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic [3:0] cmd,
    output logic       cmd_ready,
    input  logic       compA,
    input  logic       compB,
    output logic [5:0] state,
    output logic       busy,
    output logic       fault,
    output logic [7:0] fault_count
);

    localparam int DT_EFF = (DEADTIME_CYC < 1) ? 1 : DEADTIME_CYC;
    localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DT_EFF - 1);
    localparam logic [CNT_W-1:0] FH_LOAD = CNT_W'(FAULT_HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, RUN, DEAD, FAULT} st_t;

    st_t              st, st_nx;
    logic [3:0]       cur, cur_nx, pend, pend_nx, cmd_n;
    logic [CNT_W-1:0] tmr, tmr_nx;
    logic             a_s1, a_s2, b_s1, b_s2, flt_s, hs;
    logic [5:0]       state_nx;
    logic             ready_nx, busy_nx, fault_nx;

    // Synchronizers idle high (no fault) so reset never looks like an overcurrent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_s1 <= 1'b1;
            a_s2 <= 1'b1;
            b_s1 <= 1'b1;
            b_s2 <= 1'b1;
        end else begin
            a_s1 <= compA;
            a_s2 <= a_s1;
            b_s1 <= compB;
            b_s2 <= b_s1;
        end
    end

    assign flt_s = ~a_s2 | ~b_s2;
    assign hs    = cmd_valid & cmd_ready;
    // Anything other than zero or one-hot is a stop request.
    assign cmd_n = ((cmd & (cmd - 4'd1)) == 4'd0) ? cmd : 4'd0;

    always_comb begin
        st_nx   = st;
        cur_nx  = cur;
        pend_nx = pend;
        tmr_nx  = tmr;
        if (flt_s) begin
            st_nx   = FAULT;
            cur_nx  = 4'd0;
            pend_nx = 4'd0;
            tmr_nx  = FH_LOAD;
        end else begin
            case (st)
                IDLE: begin
                    if (hs && cmd_n != 4'd0) begin
                        st_nx  = RUN;
                        cur_nx = cmd_n;
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (cmd_n == 4'd0) begin
                            st_nx  = IDLE;
                            cur_nx = 4'd0;
                        end else if (cmd_n != cur) begin
                            st_nx   = DEAD;
                            pend_nx = cmd_n;
                            tmr_nx  = DT_LOAD;
                        end
                    end
                end
                DEAD: begin
                    if (tmr == '0) begin
                        st_nx  = RUN;
                        cur_nx = pend;
                    end else begin
                        tmr_nx = tmr - CNT_W'(1);
                    end
                end
                FAULT: begin
                    if (tmr == '0) st_nx = IDLE;
                    else           tmr_nx = tmr - CNT_W'(1);
                end
                default: st_nx = IDLE;
            endcase
        end
        state_nx = (st_nx == RUN) ? {2'b00, cur_nx} : 6'd0;
        ready_nx = (st_nx == IDLE) || (st_nx == RUN);
        busy_nx  = (st_nx == DEAD) || (st_nx == FAULT);
        fault_nx = (st_nx == FAULT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= IDLE;
            cur       <= 4'd0;
            pend      <= 4'd0;
            tmr       <= '0;
            state     <= 6'd0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            st        <= st_nx;
            cur       <= cur_nx;
            pend      <= pend_nx;
            tmr       <= tmr_nx;
            state     <= state_nx;
            cmd_ready <= ready_nx;
            busy      <= busy_nx;
            fault     <= fault_nx;
        end
    end

`ifdef MOTION_FAULT_COUNT_EN
    logic [7:0] fcnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            fcnt <= 8'd0;
        else if (flt_s && st != FAULT && fcnt != 8'hFF)
            fcnt <= fcnt + 8'd1;
    end
    assign fault_count = fcnt;
`else
    assign fault_count = 8'd0;
`endif

endmodule

// File: doc/motion_state_sequencer.md
# motion_state_sequencer

Produces the one-hot 6-bit motion `state` vector consumed by the H-bridge motor driver. It accepts direction commands from upstream control logic over a valid/ready handshake. Whenever the drive direction changes, it inserts a stop dead-time so the bridge never switches directly between opposing polarities. It latches overcurrent faults from the current comparators and holds the motors stopped until both comparators have been clear for a programmable time.

## Interface
Parameters:
- `DEADTIME_CYC`, default 50000: cycles `state` is held at stop between two different non-stop directions.
- `FAULT_HOLD_CYC`, default 10000000: consecutive fault-free cycles required to leave FAULT.
- `CNT_W`, default 24: timer width; must satisfy 2^CNT_W > max(DEADTIME_CYC, FAULT_HOLD_CYC).

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd` in 4: requested direction. Encodings: 0000 stop, 0001 forward, 0010 backward, 0100 right, 1000 left.
- `cmd_ready` out 1: command can be accepted. The command transfers on a rising edge where `cmd_valid && cmd_ready`.
- `compA`, `compB` in 1 each: overcurrent comparators, asynchronous. Low means fault.
- `state` out 6: motion code to the driver. Bits [5:4] are always 0; bits [3:0] use the `cmd` encodings.
- `busy` out 1: high in DEAD or FAULT.
- `fault` out 1: high in FAULT.
- `fault_count` out 8: saturating fault counter (see Configuration).

## Operation
- `compA` and `compB` each pass through a 2-flop synchronizer. `flt_s` is the OR of the two inverted, synchronized values.
- `cmd` values that are neither zero nor one-hot are treated as stop.
- `cur` is the registered current direction. `state = {2'b00, cur}` in RUN; `state = 0` in all other states.
- FSM states:
  - IDLE (`cur=0`, `cmd_ready=1`):
    - Accepting a non-stop command → RUN with `cur=cmd`.
    - Accepting a stop command → remain in IDLE.
  - RUN (`cmd_ready=1`):
    - Accepting `cmd==cur` → no change.
    - Accepting stop → IDLE.
    - Accepting any other direction → latch it as `pend`, load the timer with DEADTIME_CYC-1, go to DEAD.
  - DEAD (`cmd_ready=0`, `busy=1`): count the timer down. At 0 → RUN with `cur=pend`.
  - FAULT (`cmd_ready=0`, `busy=1`, `fault=1`):
    - The timer reloads to FAULT_HOLD_CYC-1 on every cycle where `flt_s=1`.
    - When `flt_s=0` and the timer reaches 0 → IDLE.
- From any state, `flt_s=1` → FAULT. The transition clears `cur` and `pend`.
- Priority within one cycle: fault beats the handshake, which beats timer expiry. A handshake that completes on the same edge as FAULT entry is consumed and discarded.
- DEADTIME_CYC=0 is treated as 1.

## Timing
- Reset values: `state=0`, `cmd_ready=0`, `busy=0`, `fault=0`, `fault_count=0`; FSM in IDLE. `cmd_ready` rises on the first edge after `reset_n` deasserts.
- All outputs are registered.
- Handshake at edge k → new `state` visible after edge k. Latency is 1 cycle.
- Direction change accepted at edge k: `state=0` for exactly DEADTIME_CYC cycles. The new direction appears after edge k+DEADTIME_CYC, and `cmd_ready` returns at the same edge.
- Fault response: once comp is low at edge k, `state=0` and `fault=1` after edge k+2.
- Fault release: once both comps are high from edge j onward, IDLE is entered after edge j+2+FAULT_HOLD_CYC-1. A glitch of any length restarts the count.
- Reset asserted mid-DEAD or mid-FAULT: outputs go to their reset values immediately and `pend` is lost.

## Configuration
- `MOTION_FAULT_COUNT_EN` defined: `fault_count` increments by 1 on each FAULT entry and saturates at 255. It is cleared only by reset.
- `MOTION_FAULT_COUNT_EN` undefined: `fault_count` is tied to 0 and no counter logic is built.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use DEADTIME_CYC=4 and FAULT_HOLD_CYC=8.
- Reset, then `cmd=0001` with valid held → `cmd_ready=1` one edge after release; `state=000001` one cycle after the handshake; `busy=0`.
- In forward, send `cmd=0010` → `state=000000` for exactly 4 cycles, then 000010. `cmd_ready=0` and `busy=1` during the gap.
- In right (000100), send `cmd=0011` → treated as stop: `state=000000` next cycle, FSM in IDLE, no dead-time.
- In left, pull `compB` low for 1 cycle → `state=0` and `fault=1` after edge k+2. IDLE is reached 2+7 edges after `compB` rises. `fault_count=1` with the macro defined, 0 without it.
- During FAULT, pulse `compA` low once → the hold count restarts. In the same test, a handshake on the FAULT-entry edge is discarded and `state` stays 0.
- Assert `reset_n` mid-DEAD → `state=0` and `busy=0` immediately; after release, `state` stays 000000 with no pending direction applied.
